// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor PWM driver: gate FSM state encoding,
// PWM counter terminal count, ADC trigger fallback position and duty width.
// No ports (package).
// ---------------------------------------------------------------------------
package motor_pkg;

    localparam int          DUTY_W           = 8;
    localparam logic [7:0]  PWM_PERIOD_MAX   = 8'd254;
    // Mid off-time sample point used when the on-time is too short to
    // centre the ADC trigger inside it.
    localparam logic [7:0]  ADC_TRIG_OFF_POS = 8'd128;

    typedef enum logic [2:0] {
        G_OFF,
        G_LO,
        G_DT_R,
        G_HI,
        G_DT_F
    } gate_state_t;

endpackage

// File: rtl/deadtime_gate.sv
// ---------------------------------------------------------------------------
// deadtime_gate
// Complementary half-bridge gate FSM with dead-time insertion. The low side
// is always the starting point after the bridge has been off; a switch to the
// opposite side only completes once the demand has been held steady for
// DEADTIME cycles with both gates low. Gates are registered copies of the
// next state, so they never glitch and are never high together.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   raw_on  in   high-side demand from the PWM comparator
//   enable  in   bridge enable; low forces the bridge off
//   fault   in   fault present (live or latched); forces the bridge off
//   pwm_hi  out  high-side gate
//   pwm_lo  out  low-side gate
// ---------------------------------------------------------------------------
module deadtime_gate
    import motor_pkg::*;
#(
    parameter int DEADTIME = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_on,
    input  logic enable,
    input  logic fault,
    output logic pwm_hi,
    output logic pwm_lo
);

    // Counting down from DEADTIME-1 to 0 gives exactly DEADTIME dead cycles.
    localparam logic [3:0] DT_LOAD = 4'(DEADTIME - 1);

    gate_state_t state;
    gate_state_t state_nxt;
    logic [3:0]  dt_cnt;
    logic [3:0]  dt_cnt_nxt;
    logic        hi_nxt;
    logic        lo_nxt;

    always_comb begin
        state_nxt  = state;
        dt_cnt_nxt = dt_cnt;
        if (!enable || fault) begin
            state_nxt  = G_OFF;
            dt_cnt_nxt = 4'd0;
        end else begin
            case (state)
                G_OFF: begin
                    state_nxt = G_LO;
                end
                G_LO: begin
                    if (raw_on) begin
                        state_nxt  = G_DT_R;
                        dt_cnt_nxt = DT_LOAD;
                    end
                end
                G_DT_R: begin
                    // Demand withdrawn before the high side turned on:
                    // fall back without ever pulsing pwm_hi.
                    if (!raw_on) begin
                        state_nxt = G_LO;
                    end else if (dt_cnt == 4'd0) begin
                        state_nxt = G_HI;
                    end else begin
                        dt_cnt_nxt = dt_cnt - 4'd1;
                    end
                end
                G_HI: begin
                    if (!raw_on) begin
                        state_nxt  = G_DT_F;
                        dt_cnt_nxt = DT_LOAD;
                    end
                end
                G_DT_F: begin
                    // The low side never came on, so the high side can be
                    // re-applied immediately without a shoot-through risk.
                    if (raw_on) begin
                        state_nxt = G_HI;
                    end else if (dt_cnt == 4'd0) begin
                        state_nxt = G_LO;
                    end else begin
                        dt_cnt_nxt = dt_cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = G_OFF;
                end
            endcase
        end
        hi_nxt = (state_nxt == G_HI);
        lo_nxt = (state_nxt == G_LO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= G_OFF;
            dt_cnt <= 4'd0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_cnt_nxt;
            pwm_hi <= hi_nxt;
            pwm_lo <= lo_nxt;
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// motor_pwm_driver
// Converts the 8-bit duty command from the current-control loop into a
// complementary half-bridge gate pair. The duty command is clamped for
// minimum pulse width and shadow-loaded only at the end of each PWM period,
// so mid-period command changes never disturb the running period. An ADC
// trigger is emitted at the centre of the on-time, and gate faults are
// latched until explicitly cleared.
//
// Ports:
//   c20k           in   system clock
//   reset          in   synchronous active-high reset
//   MotorSignal    in   unsigned duty command (0 = off, 255 = full on)
//   enable         in   bridge enable; low forces both gates off
//   fault_in       in   gate-driver fault, active-high
//   fault_clear    in   single-cycle pulse clearing a latched fault
//   pwm_hi         out  high-side gate
//   pwm_lo         out  low-side gate
//   period_start   out  one-cycle pulse while the counter is 0
//   adc_trigger    out  one-cycle pulse at the on-time centre
//   duty_active    out  clamped duty currently applied
//   fault_latched  out  sticky fault flag
// ---------------------------------------------------------------------------
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int DEADTIME   = 2,
    parameter int MIN_PULSE  = 2,
    parameter int PERIOD_MAX = int'(PWM_PERIOD_MAX)
) (
    input  logic              c20k,
    input  logic              reset,
    input  logic [DUTY_W-1:0] MotorSignal,
    input  logic              enable,
    input  logic              fault_in,
    input  logic              fault_clear,
    output logic              pwm_hi,
    output logic              pwm_lo,
    output logic              period_start,
    output logic              adc_trigger,
    output logic [DUTY_W-1:0] duty_active,
    output logic              fault_latched
);

    localparam logic [DUTY_W-1:0] CNT_TC = DUTY_W'(PERIOD_MAX);

    // Pulses narrower than MIN_PULSE (at either end) are not worth switching.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        if (int'(d) < MIN_PULSE) begin
            return '0;
        end else if (int'(d) > 255 - MIN_PULSE) begin
            return '1;
        end
        return d;
    endfunction

    // Short on-times cannot hold a stable sample point, so sample in the
    // middle of the off-time instead.
    function automatic logic [DUTY_W-1:0] trig_pos(input logic [DUTY_W-1:0] d);
        if (d >= DUTY_W'(4)) begin
            return d >> 1;
        end
        return ADC_TRIG_OFF_POS;
    endfunction

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic              at_tc;
    logic              raw_on;
    logic              fault_any;

    always_comb begin
        at_tc     = (cnt == CNT_TC);
        cnt_nxt   = at_tc ? '0 : cnt + DUTY_W'(1);
        duty_nxt  = at_tc ? clamp_duty(MotorSignal) : duty_active;
        raw_on    = (cnt < duty_active);
        // The live fault input is included so the bridge drops in the very
        // next cycle rather than waiting for the latch to update.
        fault_any = fault_in | fault_latched;
    end

    // Pulses are computed from next-cycle counter/duty so that they are
    // registered yet coincide with the counter value they refer to; the
    // first counter-0 cycle after reset therefore carries no period_start.
    always_ff @(posedge c20k) begin
        if (reset) begin
            cnt           <= '0;
            duty_active   <= '0;
            period_start  <= 1'b0;
            adc_trigger   <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            duty_active  <= duty_nxt;
            period_start <= (cnt_nxt == '0);
            adc_trigger  <= (cnt_nxt == trig_pos(duty_nxt));
            if (fault_in) begin
                fault_latched <= 1'b1;
            end else if (fault_clear) begin
                fault_latched <= 1'b0;
            end
        end
    end

    deadtime_gate #(
        .DEADTIME (DEADTIME)
    ) u_gate (
        .clk    (c20k),
        .reset  (reset),
        .raw_on (raw_on),
        .enable (enable),
        .fault  (fault_any),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_motor_pwm_driver
// Directed scenarios followed by randomized stimulus, every cycle compared
// against a behavioural model of the driver built from the cycle count since
// reset, the shadow-loaded duty and a "which side owns the bridge" view of
// the gates.
// ---------------------------------------------------------------------------
module tb_motor_pwm_driver;

    localparam int DEADTIME  = 2;
    localparam int MIN_PULSE = 2;
    localparam int PERIOD    = 255;

    logic       c20k = 1'b0;
    logic       reset;
    logic [7:0] MotorSignal;
    logic       enable;
    logic       fault_in;
    logic       fault_clear;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;
    logic       adc_trigger;
    logic [7:0] duty_active;
    logic       fault_latched;

    int errors = 0;
    int checks = 0;

    // Model state: cycles since reset, applied duty, fault latch, and the
    // side currently owning the bridge (0 none, 1 low, 2 high) plus how many
    // consecutive cycles the demand has pointed at the other side.
    int m_t     = 0;
    int m_duty  = 0;
    int m_lat   = 0;
    int m_owner = 0;
    int m_wait  = 0;
    int m_hi    = 0;
    int m_lo    = 0;
    int m_ps    = 0;
    int m_adc   = 0;

    motor_pwm_driver #(
        .DEADTIME   (DEADTIME),
        .MIN_PULSE  (MIN_PULSE),
        .PERIOD_MAX (PERIOD - 1)
    ) dut (
        .c20k          (c20k),
        .reset         (reset),
        .MotorSignal   (MotorSignal),
        .enable        (enable),
        .fault_in      (fault_in),
        .fault_clear   (fault_clear),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .period_start  (period_start),
        .adc_trigger   (adc_trigger),
        .duty_active   (duty_active),
        .fault_latched (fault_latched)
    );

    always #5 c20k = ~c20k;

    function automatic int clamp_ref(input int v);
        if (v < MIN_PULSE) return 0;
        if (v > 255 - MIN_PULSE) return 255;
        return v;
    endfunction

    function automatic int sample_pos(input int d);
        return (d >= 4) ? d / 2 : 128;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, req, m_t);
        end
    endtask

    // Advance the model across one clock edge, then compare every output.
    task automatic tick();
        int raw;
        int ok;
        int want;
        if (reset) begin
            m_t = 0; m_duty = 0; m_lat = 0;
            m_owner = 0; m_wait = 0;
        end else begin
            raw = ((m_t % PERIOD) < m_duty) ? 1 : 0;
            ok  = (enable && !(fault_in || m_lat != 0)) ? 1 : 0;
            if (!ok) begin
                m_owner = 0;
                m_wait  = 0;
            end else if (m_owner == 0) begin
                m_owner = 1;
                m_wait  = 0;
            end else begin
                want = raw ? 2 : 1;
                if (want == m_owner) begin
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait > DEADTIME) begin
                        m_owner = want;
                        m_wait  = 0;
                    end
                end
            end
            if ((m_t % PERIOD) == PERIOD - 1) m_duty = clamp_ref(int'(MotorSignal));
            if (fault_in) m_lat = 1;
            else if (fault_clear) m_lat = 0;
            m_t++;
        end
        m_hi  = (m_wait == 0 && m_owner == 2) ? 1 : 0;
        m_lo  = (m_wait == 0 && m_owner == 1) ? 1 : 0;
        m_ps  = (m_t > 0 && (m_t % PERIOD) == 0) ? 1 : 0;
        m_adc = (m_t > 0 && (m_t % PERIOD) == sample_pos(m_duty)) ? 1 : 0;
        @(posedge c20k);
        #1;
        chk("pwm_hi", 16'(pwm_hi), 16'(m_hi));
        chk("pwm_lo", 16'(pwm_lo), 16'(m_lo));
        chk("gate_overlap", 16'(pwm_hi & pwm_lo), 16'd0);
        chk("period_start", 16'(period_start), 16'(m_ps));
        chk("adc_trigger", 16'(adc_trigger), 16'(m_adc));
        chk("duty_active", 16'(duty_active), 16'(m_duty));
        chk("fault_latched", 16'(fault_latched), 16'(m_lat));
    endtask

    // Run until the model counter reaches c (at most one period).
    task automatic run_to(input int c);
        for (int i = 0; i < PERIOD && (m_t % PERIOD) != c; i++) tick();
    endtask

    // Observe one full period starting at counter 0.
    task automatic measure(output int hi_n, output int lo_n, output int adc_at);
        hi_n = 0; lo_n = 0; adc_at = -1;
        run_to(0);
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_hi) hi_n++;
            if (pwm_lo) lo_n++;
            if (adc_trigger) adc_at = m_t % PERIOD;
            if (i < PERIOD - 1) tick();
        end
    endtask

    initial begin
        int hi_n, lo_n, adc_at;
        int en_off;
        logic [7:0] edge_vals [10];
        edge_vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd252, 8'd253, 8'd254, 8'd255};

        reset = 1'b1; MotorSignal = 8'd0; enable = 1'b0;
        fault_in = 1'b0; fault_clear = 1'b0;
        repeat (3) tick();
        chk("reset_hi", 16'(pwm_hi), 16'd0);
        chk("reset_duty", 16'(duty_active), 16'd0);
        chk("reset_ps", 16'(period_start), 16'd0);
        reset = 1'b0;

        // Half duty: gate widths, dead-time gaps and centred sample point.
        enable = 1'b1; MotorSignal = 8'd128;
        run_to(PERIOD - 1); tick();
        tick();
        measure(hi_n, lo_n, adc_at);
        chk("d128_hi_cycles", 16'(hi_n), 16'd126);
        chk("d128_lo_cycles", 16'(lo_n), 16'd125);
        chk("d128_adc_pos", 16'(adc_at), 16'd64);

        // Minimum-pulse clamp at both ends.
        MotorSignal = 8'd1;
        run_to(PERIOD - 1); tick(); tick();
        measure(hi_n, lo_n, adc_at);
        chk("d1_duty", 16'(duty_active), 16'd0);
        chk("d1_hi_cycles", 16'(hi_n), 16'd0);
        chk("d1_adc_pos", 16'(adc_at), 16'd128);
        MotorSignal = 8'd254;
        run_to(PERIOD - 1); tick(); tick();
        measure(hi_n, lo_n, adc_at);
        chk("d254_duty", 16'(duty_active), 16'd255);
        chk("d254_hi_cycles", 16'(hi_n), 16'd255);
        chk("d254_lo_cycles", 16'(lo_n), 16'd0);
        chk("d254_adc_pos", 16'(adc_at), 16'd127);

        // Shadow load: mid-period change only takes effect next period.
        MotorSignal = 8'd50;
        run_to(PERIOD - 1); tick();
        run_to(100);
        MotorSignal = 8'd200;
        run_to(PERIOD - 1);
        chk("shadow_hold", 16'(duty_active), 16'd50);
        tick();
        chk("shadow_load", 16'(duty_active), 16'd200);
        chk("shadow_ps", 16'(period_start), 16'd1);

        // Fault during high side, clear ignored while fault persists.
        run_to(20);
        chk("pre_fault_hi", 16'(pwm_hi), 16'd1);
        fault_in = 1'b1; tick();
        chk("fault_gates", 16'({pwm_hi, pwm_lo}), 16'd0);
        chk("fault_set", 16'(fault_latched), 16'd1);
        fault_clear = 1'b1; tick();
        chk("clear_ignored", 16'(fault_latched), 16'd1);
        fault_in = 1'b0; fault_clear = 1'b0; tick();
        fault_clear = 1'b1; tick();
        fault_clear = 1'b0;
        chk("fault_cleared", 16'(fault_latched), 16'd0);
        tick();
        chk("restart_lo", 16'({pwm_hi, pwm_lo}), 16'd1);

        // Reset mid-period with duty 200.
        run_to(170);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_duty", 16'(duty_active), 16'd0);
        chk("rst_mid_gates", 16'({pwm_hi, pwm_lo}), 16'd0);
        chk("rst_mid_pulses", 16'({period_start, adc_trigger}), 16'd0);
        run_to(PERIOD - 1); tick();
        chk("rst_reload", 16'(duty_active), 16'd200);

        // Enable dropped for 3 cycles in the on-time.
        run_to(50);
        enable = 1'b0; tick();
        chk("dis_gates", 16'({pwm_hi, pwm_lo}), 16'd0);
        tick(); tick();
        enable = 1'b1; tick();
        chk("reen_lo_first", 16'({pwm_hi, pwm_lo}), 16'd1);
        tick();
        chk("reen_dead", 16'({pwm_hi, pwm_lo}), 16'd0);
        tick(); tick();
        chk("reen_hi", 16'({pwm_hi, pwm_lo}), 16'd2);

        // Randomized commands, enable drops and fault activity.
        en_off = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    MotorSignal = edge_vals[$urandom_range(0, 9)];
                else
                    MotorSignal = 8'($urandom_range(0, 255));
            end
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 399) == 0) en_off = int'($urandom_range(1, 6));
            enable      = (en_off == 0);
            fault_in    = ($urandom_range(0, 799) == 0);
            fault_clear = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Consumer end of the 8-bit MotorSignal duty command produced by the current-control loop.
- Turns the duty command into a complementary half-bridge gate pair (high side and low side) with dead-time insertion, minimum-pulse clamping, and glitch-free duty updates at period boundaries.
- Emits an ADC sample trigger at the centre of the on-time, so the phase-wire voltage fed back to current control is sampled at a stable point.
- Latches gate faults and holds the bridge off until a fault is explicitly cleared.

Parameters:
- DEADTIME, 2, clock cycles both gates are held low on every gate transition (1..15).
- MIN_PULSE, 2, duty below this snaps to 0; duty above 255-MIN_PULSE snaps to 255.
- PERIOD_MAX, 254, terminal count of the PWM counter; period = PERIOD_MAX+1 = 255 cycles.

Ports:
- c20k  in  1  system clock
- reset  in  1  synchronous, active-high reset
- MotorSignal  in  8  unsigned duty command; 0 = off, 255 = full on
- enable  in  1  bridge enable; low forces both gates off
- fault_in  in  1  gate-driver fault, active-high
- fault_clear  in  1  single-cycle pulse that clears a latched fault
- pwm_hi  out  1  high-side gate
- pwm_lo  out  1  low-side gate
- period_start  out  1  one-cycle pulse when counter = 0
- adc_trigger  out  1  one-cycle pulse at on-time centre
- duty_active  out  8  clamped duty currently applied
- fault_latched  out  1  sticky fault flag

Behaviour:
- Reset: all outputs 0, counter 0, gate FSM to G_OFF, fault_latched 0.
- Counter: 8-bit, increments each cycle; wraps PERIOD_MAX -> 0. period_start is registered and pulses during the cycle the counter equals 0.
- Clamp: clamped = 0 if MotorSignal < MIN_PULSE; clamped = 255 if MotorSignal > 255-MIN_PULSE; otherwise clamped = MotorSignal.
- Shadow load: duty_active <= clamped only on the cycle the counter equals PERIOD_MAX. MotorSignal changes mid-period never affect the current period.
- Raw demand: raw_on = (counter < duty_active). duty 255 is therefore on for all 255 counts (100%); duty 0 is never on.
- Gate FSM states: G_OFF, G_LO, G_DT_R, G_HI, G_DT_F. The dead-time counter is 4 bits.
  - G_OFF: both gates 0. Leave to G_LO when enable=1 and fault_latched=0.
  - G_LO: pwm_lo=1. If raw_on, go to G_DT_R and load the dead-time counter.
  - G_DT_R: both gates 0 for DEADTIME cycles, then go to G_HI. If raw_on drops during dead time, return to G_LO without asserting pwm_hi.
  - G_HI: pwm_hi=1. If !raw_on, go to G_DT_F.
  - G_DT_F: both gates 0 for DEADTIME cycles, then go to G_LO. If raw_on rises during dead time, return to G_HI.
  - Any state: enable=0 or fault_latched=1 sends the FSM to G_OFF on the next cycle. Gates are registered, so they are low within 1 cycle.
- Gate invariant: pwm_hi and pwm_lo are never both 1 in any cycle.
- Gate latency: 1 cycle after raw_on changes when no dead time applies; DEADTIME+1 cycles across a dead-time transition.
- ADC trigger: pulses when counter = duty_active>>1, only if duty_active >= 4. Otherwise it pulses at counter = 128 (mid off-time). Exactly one pulse per period.
- Fault handling:
  - fault_latched sets on fault_in=1.
  - It clears on fault_clear=1 only if fault_in=0 that cycle.
  - If set and clear arrive in the same cycle, set wins.
- Reset mid-period: counter restarts at 0 and duty_active returns to 0. The next load happens at the next PERIOD_MAX.
- Enable re-assertion: the bridge restarts through G_LO. It never goes directly to G_HI.

Decomposition:
- Shared package motor_pkg:
  - gate_state_t enum (G_OFF, G_LO, G_DT_R, G_HI, G_DT_F).
  - Constants PWM_PERIOD_MAX, ADC_TRIG_OFF_POS (128), DUTY_W (8).
- One sub-module, deadtime_gate: contains the gate FSM and dead-time counter. Takes raw_on, enable and fault; drives pwm_hi and pwm_lo.
- Counter, clamp, shadow register, trigger and fault latch stay in the top module.

Test Plan:
- MotorSignal=128 held, enable=1, DEADTIME=2 -> per 255-cycle period, pwm_hi high for 126 cycles and pwm_lo high for 125 cycles. Gates are never high together, with a 2-cycle gap at each edge. adc_trigger pulses at counter 64.
- MotorSignal=1 then 254 -> duty_active=0 (pwm_hi never asserts, adc_trigger at counter 128), then duty_active=255 (pwm_hi continuously high after the first rise, pwm_lo never asserts).
- MotorSignal changed 50 -> 200 at counter 100 -> duty_active stays 50 until counter=254, then becomes 200. The first period with 200 starts at the following counter 0.
- fault_in pulsed while pwm_hi=1 -> both gates 0 on the next cycle and fault_latched=1. fault_clear while fault_in=1 is ignored. fault_clear after fault_in=0 clears the flag and the bridge restarts via pwm_lo.
- reset asserted at counter 170 with duty 200 -> the next cycle has counter 0, both gates 0, duty_active 0 and all pulses 0. Normal operation resumes after one full period.
- enable toggled low for 3 cycles mid on-time -> gates drop to 0 within 1 cycle. On re-enable, pwm_lo asserts first, then pwm_hi only after DEADTIME cycles if raw_on is still true.
